i2c_burst_master: RTL and testbench
===================================

# i2c_burst_master

Parametrised I2C master with multi-byte bursts. It performs register-addressed write and read transactions of 0..MAX_LEN data bytes to any 7-bit device, with a programmable SCL rate and detection of a slave NACK. Data moves through a byte-wide streaming handshake, so the host logic never handles bit timing. It succeeds the single-byte master in the I2C subsystem and drives an open-drain SDA/SCL pad pair.

## Interface
Parameters:
- CLK_DIV, 125: system clocks per SCL quarter period. Must be ≥ 2. SCL period = 4*CLK_DIV clocks; 100 kHz at 50 MHz.
- MAX_LEN, 8: maximum burst length in bytes.
- LEN_W, 4: width of `len`. Must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- rw  in  1  0 = write, 1 = read. Latched on an accepted start.
- devAddr  in  7  slave address. Latched on start.
- regAddr  in  8  slave register address. Latched on start.
- len  in  LEN_W  byte count. Latched on start; values above MAX_LEN are clamped to MAX_LEN.
- wrData  in  8  next write byte. Sampled when wrReq is high.
- wrReq  out  1  one-cycle pulse: wrData has been captured for the current byte, so present the next one.
- rdData  out  8  last received byte.
- rdValid  out  1  one-cycle pulse: rdData has been updated.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse at transaction end.
- ackErr  out  1  a slave NACK occurred in the last transaction. Held until the next accepted start.
- scl  out  1  SCL level. Push-pull; no clock stretching.
- sdaOe  out  1  1 = drive SDA low, 0 = release.
- sdaIn  in  1  sampled SDA pad level.

## Operation
- Write sequence: START, then {devAddr,0}, ACK, regAddr, ACK, then len data bytes each followed by an ACK, then STOP.
- Read sequence: START, then {devAddr,0}, ACK, regAddr, ACK, then repeated START, then {devAddr,1}, ACK, then len bytes.
  - The master ACKs every read byte except the last, which it NACKs.
  - STOP follows the last byte.
- len = 0: both modes run the address phase only (devAddr+W, regAddr), then STOP. A read with len = 0 issues no repeated START.
- Bytes are sent MSB first.
- States: IDLE, START, ADDR, ACK_S, REG, ACK_S, WDATA, ACK_S, RSTART, ADDR_R, ACK_S, RDATA, ACK_M, STOP, DONE. ACK_S is shared and its return target is held in a register.
- Byte counter: loads the clamped len on start and decrements after each data byte's ACK. A count of 0 selects STOP.
- Slave NACK (sdaIn = 1 in any ACK_S bit): set ackErr, abort the remaining bytes, go to STOP, then DONE. No wrReq or rdValid pulses occur after a NACK.
- rdData is updated at the end of bit 8 of each read byte. rdValid pulses in the same cycle.
- wrReq pulses in the cycle WDATA loads its shift register from wrData.
- A start while busy is ignored and has no side effects.

## Timing
- A quarter-tick counter divides clk by CLK_DIV. Every bit, START, RSTART and STOP lasts exactly 4 quarters (q0..q3).
- Data/ACK bit:
  - q0–q1: SCL low. SDA is changed at q0 entry.
  - q2–q3: SCL high. sdaIn is sampled on the first clock of q3.
- START: SDA released and SCL high for q0–q1; SDA low at q2; SCL low at q3.
- RSTART: SDA released and SCL low at q0; SCL high at q1; SDA low at q2; SCL low at q3.
- STOP: SDA low and SCL low at q0; SCL high at q1; SDA released at q2; held through q3.
- Accepted start: busy is high the next cycle and START q0 begins that cycle.
- Total clocks from start to done, with T = 4*CLK_DIV:
  - write: T*(20+9*len)
  - read, len > 0: T*(30+9*len)
  - read, len = 0: T*20
- done pulses 1 cycle after STOP q3 ends. busy falls in the same cycle as done.
- Reset values: scl=1, sdaOe=0, busy=0, done=0, ackErr=0, wrReq=0, rdValid=0, rdData=8'h00, state IDLE.
- Reset mid-transfer releases the bus immediately (scl=1, sdaOe=0) without generating a STOP. All counters clear.

## Test plan
- Write, CLK_DIV=4, devAddr=7'h40, regAddr=8'h01, len=2, wrData 8'hBA then 8'h5C, slave model ACKs everything.
  - Required: SDA bytes 8'h80, 8'h01, 8'hBA, 8'h5C; exactly 2 wrReq pulses; done after 16*38 clocks; ackErr=0.
- Read, devAddr=7'h40, regAddr=8'h01, len=3, slave returns 8'hA5, 8'h3C, 8'hFF.
  - Required: repeated START, then 8'h81.
  - Required: 3 rdValid pulses carrying those values, with master ACK, ACK, NACK; then STOP; done after 16*57 clocks.
- Address NACK: slave NACKs 8'h80.
  - Required: ackErr=1, STOP immediately after, no wrReq or rdValid pulses.
  - Required: ackErr stays 1 until the next start, then clears.
- len=0 read: only 8'h80 and regAddr are sent, no RSTART, done after 16*20 clocks. Also len=12 must be clamped to 8 bytes.
- A start pulse while busy is ignored: the byte sequence and done timing are unchanged, and only one done pulse occurs.
- rst asserted during the second data byte: scl=1 and sdaOe=0 within the same cycle, all outputs at reset values. A new write after release completes normally.

Source files
------------

// File: rtl/i2c_burst_master.sv
// I2C master performing register-addressed burst writes and reads of 0..MAX_LEN bytes.
// Host data moves through a byte-wide wrReq/rdValid handshake; SCL/SDA drive an open-drain pad.
module i2c_burst_master #(
    parameter int unsigned CLK_DIV = 125,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       devAddr,
    input  logic [7:0]       regAddr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wrData,
    output logic             wrReq,
    output logic [7:0]       rdData,
    output logic             rdValid,
    output logic             busy,
    output logic             done,
    output logic             ackErr,
    output logic             scl,
    output logic             sdaOe,
    input  logic             sdaIn
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAckS, StReg, StWdata, StRstart,
        StAddrR, StRdata, StAckM, StStop, StDone
    } state_t;

    state_t           r_state, w_state, r_ret, w_ret;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit, w_bit;
    logic [7:0]       r_sh, w_sh;
    logic [LEN_W-1:0] r_cnt, w_cnt;
    logic             r_nack, w_nack;
    logic             r_rw, w_rw;
    logic [6:0]       r_dev, w_dev;
    logic [7:0]       r_reg, w_reg;
    logic [7:0]       r_rd_data, w_rd_data;
    logic             r_rd_valid, w_rd_valid;
    logic             r_wr_req, w_wr_req;
    logic             r_ack_err, w_ack_err;
    logic             w_scl, w_sda_oe;
    logic             w_tick, w_bit_end, w_sample;
    logic [LEN_W-1:0] w_len_clamp;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_bit_end   = w_tick && (r_q == 2'd3);
    assign w_sample    = (r_q == 2'd3) && (r_div == '0);
    assign w_len_clamp = (len > LEN_MAX) ? LEN_MAX : len;

    // Quarter-period timebase; parked at q0 outside a transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_q   <= '0;
        end else if (r_state == StIdle || r_state == StDone) begin
            r_div <= '0;
            r_q   <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            r_q   <= r_q + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_ret      = r_ret;
        w_bit      = r_bit;
        w_sh       = r_sh;
        w_cnt      = r_cnt;
        w_nack     = r_nack;
        w_rw       = r_rw;
        w_dev      = r_dev;
        w_reg      = r_reg;
        w_rd_data  = r_rd_data;
        w_rd_valid = 1'b0;
        w_wr_req   = 1'b0;
        w_ack_err  = r_ack_err;
        w_scl      = 1'b1;
        w_sda_oe   = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state   = StStart;
                    w_rw      = rw;
                    w_dev     = devAddr;
                    w_reg     = regAddr;
                    w_cnt     = w_len_clamp;
                    w_ack_err = 1'b0;
                end
            end
            StStart: begin
                w_scl    = (r_q != 2'd3);
                w_sda_oe = r_q[1];
                if (w_bit_end) begin
                    w_state = StAddr;
                    w_sh    = {r_dev, 1'b0};
                    w_bit   = '0;
                end
            end
            StAddr, StReg, StWdata, StAddrR: begin
                w_scl    = r_q[1];
                w_sda_oe = ~r_sh[7];
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state = StAckS;
                        w_bit   = '0;
                        // ACK_S is shared; decide here where it resumes on a slave ACK.
                        case (r_state)
                            StAddr:  w_ret = StReg;
                            StReg:   w_ret = (r_cnt == '0) ? StStop :
                                             (r_rw ? StRstart : StWdata);
                            StWdata: begin
                                w_cnt = r_cnt - 1'b1;
                                w_ret = (r_cnt == LEN_W'(1)) ? StStop : StWdata;
                            end
                            default: w_ret = StRdata;
                        endcase
                    end else begin
                        w_bit = r_bit + 3'd1;
                        w_sh  = {r_sh[6:0], 1'b0};
                    end
                end
            end
            StAckS: begin
                w_scl = r_q[1];
                if (w_sample) w_nack = sdaIn;
                if (w_bit_end) begin
                    if (r_nack) begin
                        w_ack_err = 1'b1;
                        w_state   = StStop;
                    end else begin
                        w_state = r_ret;
                        if (r_ret == StReg) w_sh = r_reg;
                        if (r_ret == StWdata) begin
                            w_sh     = wrData;
                            w_wr_req = 1'b1;
                        end
                    end
                end
            end
            StRstart: begin
                w_scl    = (r_q == 2'd1) || (r_q == 2'd2);
                w_sda_oe = r_q[1];
                if (w_bit_end) begin
                    w_state = StAddrR;
                    w_sh    = {r_dev, 1'b1};
                    w_bit   = '0;
                end
            end
            StRdata: begin
                w_scl = r_q[1];
                if (w_sample) w_sh = {r_sh[6:0], sdaIn};
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_rd_data  = r_sh;
                        w_rd_valid = 1'b1;
                        w_state    = StAckM;
                        w_bit      = '0;
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end
            end
            StAckM: begin
                w_scl    = r_q[1];
                w_sda_oe = (r_cnt != LEN_W'(1));
                if (w_bit_end) begin
                    w_cnt   = r_cnt - 1'b1;
                    w_state = (r_cnt == LEN_W'(1)) ? StStop : StRdata;
                end
            end
            StStop: begin
                w_scl    = (r_q != 2'd0);
                w_sda_oe = ~r_q[1];
                if (w_bit_end) w_state = StDone;
            end
            StDone:  w_state = StIdle;
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_ret      <= StIdle;
            r_bit      <= '0;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_nack     <= 1'b0;
            r_rw       <= 1'b0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_req   <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ret      <= w_ret;
            r_bit      <= w_bit;
            r_sh       <= w_sh;
            r_cnt      <= w_cnt;
            r_nack     <= w_nack;
            r_rw       <= w_rw;
            r_dev      <= w_dev;
            r_reg      <= w_reg;
            r_rd_data  <= w_rd_data;
            r_rd_valid <= w_rd_valid;
            r_wr_req   <= w_wr_req;
            r_ack_err  <= w_ack_err;
        end
    end

    assign scl     = w_scl;
    assign sdaOe   = w_sda_oe;
    assign busy    = (r_state != StIdle) && (r_state != StDone);
    assign done    = (r_state == StDone);
    assign ackErr  = r_ack_err;
    assign wrReq   = r_wr_req;
    assign rdData  = r_rd_data;
    assign rdValid = r_rd_valid;

endmodule

// File: tb/tb_i2c_burst_master.sv
// Bench for i2c_burst_master: behavioural I2C slave on the bus, transaction-level expected
// byte/ACK sequence, timing and handshake counts built from the protocol rules.
module tb_i2c_burst_master;

    localparam int CLK_DIV  = 4;
    localparam int T        = 4 * CLK_DIV;
    localparam int EV_START = 32'h400;
    localparam int EV_STOP  = 32'h800;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] devAddr = '0;
    logic [7:0] regAddr = '0;
    logic [3:0] len = '0;
    logic [7:0] wrData;
    logic       wrReq, rdValid, busy, done, ackErr, scl, sdaOe, sdaIn;
    logic [7:0] rdData;

    i2c_burst_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(8), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .devAddr(devAddr),
        .regAddr(regAddr), .len(len), .wrData(wrData), .wrReq(wrReq), .rdData(rdData),
        .rdValid(rdValid), .busy(busy), .done(done), .ackErr(ackErr), .scl(scl),
        .sdaOe(sdaOe), .sdaIn(sdaIn)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Host data and slave read data, plus handshake bookkeeping.
    logic [7:0] wq[16];
    logic [7:0] rdat[16];
    int         wr_base = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] rdv_q[$];
    int         nack_at = -1;

    always_comb wrData = wq[(wr_cnt - wr_base) & 15];

    always @(negedge clk) begin
        if (wrReq) wr_cnt++;
        if (rdValid) rdv_q.push_back(rdData);
        if (done) done_cnt++;
    end

    // Open-drain bus and behavioural slave.
    logic       s_drive = 1'b0;
    logic       s_prev_scl = 1'b1, s_prev_sda = 1'b1, s_cs, s_cd, s_tx = 1'b0, s_ack = 1'b0;
    logic [7:0] s_sh = '0, s_txb = '0;
    int         s_bit = 0, s_frame = 0, s_fs = 0, s_txi = 0;
    int         ev_q[$];

    always_comb sdaIn = ~(sdaOe | s_drive);

    always @(negedge clk) begin
        if (!rst) begin
            s_prev_scl = 1'b1; s_prev_sda = 1'b1; s_drive = 1'b0; s_tx = 1'b0;
            s_bit = 0; s_frame = 0; s_fs = 0; s_txi = 0;
        end else begin
            s_cs = scl;
            s_cd = sdaIn;
            if (s_prev_scl && s_cs && s_prev_sda && !s_cd) begin
                ev_q.push_back(EV_START);
                s_bit = -1; s_fs = 0; s_tx = 1'b0; s_drive = 1'b0;
            end else if (s_prev_scl && s_cs && !s_prev_sda && s_cd) begin
                ev_q.push_back(EV_STOP);
                s_bit = 0; s_frame = 0; s_fs = 0; s_txi = 0; s_tx = 1'b0; s_drive = 1'b0;
            end else if (!s_prev_scl && s_cs) begin
                if (s_bit < 8) s_sh = {s_sh[6:0], s_cd};
                else begin
                    s_ack = s_cd;
                    ev_q.push_back(int'({s_cd, s_sh}));
                end
            end else if (s_prev_scl && !s_cs) begin
                s_bit++;
                if (s_bit == 8) begin
                    s_drive = s_tx ? 1'b0 : (s_frame != nack_at);
                end else if (s_bit == 9) begin
                    if (s_fs == 0 && s_sh[0] && !s_ack) s_tx = 1'b1;
                    else if (s_tx && s_ack) s_tx = 1'b0;
                    s_bit = 0; s_frame++; s_fs++;
                    if (s_tx) begin
                        s_txb = rdat[s_txi & 15];
                        s_txi++;
                        s_drive = ~s_txb[7];
                    end else s_drive = 1'b0;
                end else begin
                    s_drive = s_tx ? ~s_txb[7 - s_bit] : 1'b0;
                end
            end
            s_prev_scl = s_cs;
            s_prev_sda = s_cd;
        end
    end

    // Transaction-level reference: expected bus events, duration in bit units, pulse counts.
    int exp_q[$];
    int m_f, m_units, m_nwr, m_nrd;
    bit m_nacked;

    task automatic model_rx(input logic [7:0] b);
        exp_q.push_back(((m_f == nack_at) ? 256 : 0) + int'(b));
        m_units += 9;
        if (m_f == nack_at) m_nacked = 1'b1;
        m_f++;
    endtask

    task automatic run_txn(input logic t_rw, input logic [6:0] t_dev, input logic [7:0] t_reg,
                           input int t_len, input int t_nack, input int poke, input int cyc_req);
        int le, n, base_ev, base_rd, base_done, got;
        bit seen;
        le = (t_len > 8) ? 8 : t_len;
        nack_at = t_nack;
        exp_q.delete();
        m_f = 0; m_nacked = 1'b0; m_units = 2; m_nwr = 0; m_nrd = 0;
        exp_q.push_back(EV_START);
        model_rx({t_dev, 1'b0});
        if (!m_nacked) model_rx(t_reg);
        if (!m_nacked && le > 0) begin
            if (!t_rw) begin
                for (int i = 0; i < le && !m_nacked; i++) begin
                    m_nwr++;
                    model_rx(wq[i]);
                end
            end else begin
                exp_q.push_back(EV_START);
                m_units++;
                model_rx({t_dev, 1'b1});
                if (!m_nacked) begin
                    for (int i = 0; i < le; i++) begin
                        exp_q.push_back(((i == le - 1) ? 256 : 0) + int'(rdat[i]));
                        m_units += 9;
                        m_nrd++;
                    end
                end
            end
        end
        exp_q.push_back(EV_STOP);

        @(negedge clk);
        wr_base = wr_cnt; base_ev = ev_q.size(); base_rd = rdv_q.size(); base_done = done_cnt;
        rw = t_rw; devAddr = t_dev; regAddr = t_reg; len = t_len[3:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on_start", busy, 1);
        check("ackerr_clear", ackErr, 0);
        n = 0; seen = 1'b0;
        while (n < 4000 && !seen) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
                if (poke > 0 && n == poke) begin
                    start = 1'b1; rw = ~t_rw; devAddr = ~t_dev; len = 4'd1;
                end else start = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        check("cycles", n, (cyc_req != 0) ? cyc_req : m_units * T);
        check("busy_at_done", busy, 0);
        check("ackerr", ackErr, m_nacked);
        repeat (8) @(negedge clk);
        check("done_pulses", done_cnt - base_done, 1);
        check("wrreq_count", wr_cnt - wr_base, m_nwr);
        check("rdvalid_count", rdv_q.size() - base_rd, m_nrd);
        for (int i = 0; i < m_nrd; i++) begin
            got = (base_rd + i < rdv_q.size()) ? int'(rdv_q[base_rd + i]) : 32'hDEAD;
            check("rd_data", got, rdat[i]);
        end
        check("event_count", ev_q.size() - base_ev, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base_ev + i < ev_q.size()) ? ev_q[base_ev + i] : 32'hDEAD;
            check("bus_event", got, exp_q[i]);
        end
    endtask

    int rn;
    int r_len, r_rxf, r_nack;
    logic r_rw;

    initial begin
        for (int i = 0; i < 16; i++) begin
            wq[i] = 8'h00;
            rdat[i] = 8'h00;
        end
        #2 rst = 1'b0;
        #3;
        check("rst_scl", scl, 1);
        check("rst_sdaoe", sdaOe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ackerr", ackErr, 0);
        check("rst_rddata", rdData, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        wq[0] = 8'hBA; wq[1] = 8'h5C;
        run_txn(1'b0, 7'h40, 8'h01, 2, -1, 0, T * 38);

        rdat[0] = 8'hA5; rdat[1] = 8'h3C; rdat[2] = 8'hFF;
        run_txn(1'b1, 7'h40, 8'h01, 3, -1, 0, T * 57);

        // Reset during the second data byte of a write.
        for (int i = 0; i < 8; i++) wq[i] = 8'(i * 37 + 5);
        nack_at = -1;
        @(negedge clk);
        wr_base = wr_cnt; rw = 1'b0; devAddr = 7'h11; regAddr = 8'h22; len = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rn = 0;
        while (rn < 3000 && (wr_cnt - wr_base) < 2) begin
            @(negedge clk);
            rn++;
        end
        check("rst_reach_byte2", wr_cnt - wr_base, 2);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_scl", scl, 1);
        check("midrst_sdaoe", sdaOe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ackerr", ackErr, 0);
        check("midrst_wrreq", wrReq, 0);
        check("midrst_rdvalid", rdValid, 0);
        check("midrst_rddata", rdData, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_txn(1'b0, 7'h11, 8'h22, 3, -1, 0, T * 47);

        wq[0] = 8'h12; wq[1] = 8'h34;
        run_txn(1'b0, 7'h40, 8'h01, 2, 0, 0, 0);
        run_txn(1'b1, 7'h40, 8'h01, 0, -1, 0, T * 20);

        for (int i = 0; i < 12; i++) wq[i] = 8'($urandom);
        run_txn(1'b0, 7'h33, 8'h9A, 12, -1, 0, T * 92);
        run_txn(1'b0, 7'h2A, 8'h33, 3, -1, 40, T * 47);

        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 12; i++) begin
                wq[i] = 8'($urandom);
                rdat[i] = 8'($urandom);
            end
            r_rw = 1'($urandom);
            r_len = $urandom_range(0, 10);
            r_rxf = r_rw ? ((r_len > 0) ? 3 : 2) : 2 + ((r_len > 8) ? 8 : r_len);
            r_nack = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_rxf - 1) : -1;
            run_txn(r_rw, 7'($urandom), 8'($urandom), r_len, r_nack, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
